// File: rtl/tmr_reg_sequencer.sv
// Command sequencer for a triplicated shift register: TX/RX word transfers,
// idle-time scrub cycles that write back the voted value, and a fault counter.
module tmr_reg_sequencer #(
  parameter int WIDTH        = 4,
  parameter int SCRUB_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rx_bit,
  output logic             rx_sample,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             reg_enable,
  output logic             reg_load,
  output logic [1:0]       reg_mode,
  output logic             reg_serial_in,
  output logic [WIDTH-1:0] reg_parallel_in,
  input  logic [WIDTH-1:0] reg_parallel_out,
  input  logic             reg_serial_out,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic [7:0]       fault_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(SCRUB_PERIOD - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHIFT_TX = 3'd2;
  localparam logic [2:0] S_SHIFT_RX = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;
  localparam logic [2:0] S_SCRUB    = 3'd5;

  localparam logic [1:0] OP_TX = 2'b00;
  localparam logic [1:0] OP_RX = 2'b01;

  logic [2:0]       state, state_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [IW-1:0]    idle_cnt;
  logic [WIDTH-1:0] word;
  logic             handshake;
  logic             shifting;

  assign handshake = (state == S_IDLE) && cmd_valid;
  assign shifting  = (state == S_SHIFT_TX) || (state == S_SHIFT_RX);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_TX:   state_nxt = S_LOAD;
            OP_RX:   state_nxt = S_SHIFT_RX;
            default: state_nxt = S_IDLE;
          endcase
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt = S_SCRUB;
        end
      end
      S_LOAD:     state_nxt = S_SHIFT_TX;
      S_SHIFT_TX: if (bit_cnt == BIT_LAST) state_nxt = S_IDLE;
      S_SHIFT_RX: if (bit_cnt == BIT_LAST) state_nxt = S_RESP;
      S_RESP:     if (rsp_ready) state_nxt = S_IDLE;
      S_SCRUB:    state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      word     <= '0;
    end else begin
      state <= state_nxt;

      if (shifting && (bit_cnt != BIT_LAST)) bit_cnt <= bit_cnt + 1'b1;
      else                                   bit_cnt <= '0;

      // Reaching the last count without a command also clears it: that is the scrub cycle.
      if ((state == S_IDLE) && !cmd_valid && (idle_cnt != IDLE_LAST)) idle_cnt <= idle_cnt + 1'b1;
      else                                                            idle_cnt <= '0;

      if (handshake) word <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_cnt <= 8'd0;
    end else if (fault_clr) begin
      fault_cnt <= 8'd0;
    end else if (reg_enable && fault_in && (fault_cnt != 8'hFF)) begin
      fault_cnt <= fault_cnt + 8'd1;
    end
  end

  // Mode 11 with enable held high is the register's scrub/write-back cycle.
  always_comb begin
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_data        = '0;
    rx_sample       = 1'b0;
    tx_bit          = 1'b0;
    tx_valid        = 1'b0;
    reg_enable      = 1'b0;
    reg_load        = 1'b0;
    reg_mode        = 2'b11;
    reg_serial_in   = 1'b0;
    reg_parallel_in = '0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_LOAD: begin
        reg_enable      = 1'b1;
        reg_mode        = 2'b10;
        reg_load        = 1'b1;
        reg_parallel_in = word;
      end
      S_SHIFT_TX: begin
        reg_enable = 1'b1;
        reg_mode   = 2'b10;
        tx_valid   = 1'b1;
        tx_bit     = reg_serial_out;
      end
      S_SHIFT_RX: begin
        reg_enable    = 1'b1;
        reg_mode      = 2'b00;
        reg_serial_in = rx_bit;
        rx_sample     = 1'b1;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = reg_parallel_out;
      end
      S_SCRUB: begin
        reg_enable = 1'b1;
        reg_mode   = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tmr_reg_sequencer.sv
// Self-checking bench for tmr_reg_sequencer with a behavioural shift register
// attached and a scoreboard of expected serial bits and response words.
module tb_tmr_reg_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rx_bit;
  logic         rx_sample;
  logic         tx_bit;
  logic         tx_valid;
  logic         reg_enable;
  logic         reg_load;
  logic [1:0]   reg_mode;
  logic         reg_serial_in;
  logic [W-1:0] reg_parallel_in;
  logic [W-1:0] reg_parallel_out;
  logic         reg_serial_out;
  logic         fault_in;
  logic         fault_clr;
  logic [7:0]   fault_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic         tx_q[$];
  logic [W-1:0] rsp_q[$];
  logic         mon_bit;
  logic [W-1:0] mon_word;
  logic [W-1:0] sr;

  tmr_reg_sequencer #(.WIDTH(W), .SCRUB_PERIOD(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rx_bit(rx_bit), .rx_sample(rx_sample), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .reg_enable(reg_enable), .reg_load(reg_load), .reg_mode(reg_mode),
    .reg_serial_in(reg_serial_in), .reg_parallel_in(reg_parallel_in),
    .reg_parallel_out(reg_parallel_out), .reg_serial_out(reg_serial_out),
    .fault_in(fault_in), .fault_clr(fault_clr), .fault_cnt(fault_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Voted register: mode 10 loads/shifts right out of bit 0, mode 00 shifts in at the MSB.
  always @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else if (reg_enable) begin
      case (reg_mode)
        2'b10:   sr <= reg_load ? reg_parallel_in : {1'b0, sr[W-1:1]};
        2'b00:   sr <= {reg_serial_in, sr[W-1:1]};
        default: sr <= sr;
      endcase
    end
  end
  assign reg_parallel_out = sr;
  assign reg_serial_out   = sr[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && tx_valid) begin
      if (tx_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else begin
        mon_bit = tx_q.pop_front();
        check("tx_bit", tx_bit, mon_bit);
      end
    end
    if (rst && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        mon_word = rsp_q.pop_front();
        check("rsp_data", rsp_data, mon_word);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_tx(input logic [W-1:0] word);
    for (int i = 0; i < W; i++) tx_q.push_back(word[i]);
  endtask

  // Offers a command until accepted; returns one cycle after the handshake.
  task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data, output int waited);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    waited    = 0;
    #1;
    while (!cmd_ready && waited < 40) begin
      tick();
      #1;
      waited++;
    end
    check("cmd_accept_timeout", waited < 40, 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  task automatic rx_word(input logic [W-1:0] word);
    for (int i = 0; i < W; i++) begin
      rx_bit = word[i];
      #1;
      check("rx_sample", rx_sample, 32'd1);
      check("rx_serial_in", reg_serial_in, word[i]);
      check("rx_mode", reg_mode, 32'd0);
      tick();
    end
    rx_bit = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 32'd1);
    check({tag, "_rsp_valid"}, rsp_valid, 32'd0);
    check({tag, "_tx_valid"}, tx_valid, 32'd0);
    check({tag, "_rx_sample"}, rx_sample, 32'd0);
    check({tag, "_reg_enable"}, reg_enable, 32'd0);
    check({tag, "_reg_load"}, reg_load, 32'd0);
    check({tag, "_reg_mode"}, reg_mode, 32'd3);
    check({tag, "_tx_bit"}, tx_bit, 32'd0);
    check({tag, "_fault_cnt"}, fault_cnt, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int nr;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
    rsp_ready = 1'b0; rx_bit = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check_reset("reset");
    tick(); tick();
    rst = 1'b1;
    tick();

    // TX 0xA: LOAD in cycle 1, bits 0,1,0,1 in cycles 2..5, ready at cycle 6
    push_tx(4'hA);
    send_cmd(2'b00, 4'hA, w);
    #1;
    check("load_reg_load", reg_load, 32'd1);
    check("load_reg_mode", reg_mode, 32'd2);
    check("load_reg_enable", reg_enable, 32'd1);
    check("load_parallel_in", reg_parallel_in, 32'hA);
    check("load_cmd_ready", cmd_ready, 32'd0);
    for (int i = 0; i < W; i++) begin
      tick(); #1;
      check("tx_valid", tx_valid, 32'd1);
      check("tx_reg_load", reg_load, 32'd0);
      check("tx_cmd_ready", cmd_ready, 32'd0);
    end
    tick(); #1;
    check("tx_done_ready", cmd_ready, 32'd1);
    check("tx_done_valid", tx_valid, 32'd0);

    // RX 1,1,0,1 with three cycles of backpressure
    rsp_q.push_back(4'hB);
    send_cmd(2'b01, 4'h0, w);
    rx_word(4'b1011);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("resp_valid_hold", rsp_valid, 32'd1);
      check("resp_data_hold", rsp_data, 32'hB);
      check("resp_cmd_ready", cmd_ready, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("resp_valid_exit", rsp_valid, 32'd1);
    tick(); #1;
    check("resp_gone", rsp_valid, 32'd0);
    check("resp_idle_ready", cmd_ready, 32'd1);

    // First idle cycle after RESP: scrub exactly 16 cycles later
    nr = 0;
    for (int i = 1; i < 16; i++) begin
      tick(); #1;
      if (!cmd_ready) nr++;
    end
    check("pre_scrub_not_ready", nr, 32'd0);
    tick();
    fault_in = 1'b1;
    #1;
    check("scrub_cmd_ready", cmd_ready, 32'd0);
    check("scrub_enable", reg_enable, 32'd1);
    check("scrub_mode", reg_mode, 32'd3);
    check("scrub_load", reg_load, 32'd0);
    tick();
    fault_in = 1'b0;
    #1;
    check("scrub_fault_cnt", fault_cnt, 32'd1);
    check("post_scrub_ready", cmd_ready, 32'd1);

    // Command at idle count 15 wins over the scrub
    for (int i = 1; i < 16; i++) tick();
    push_tx(4'h6);
    send_cmd(2'b00, 4'h6, w);
    check("defer_no_wait", w, 32'd0);
    #1 check("defer_load", reg_load, 32'd1);
    for (int i = 0; i < W; i++) tick();
    tick();

    // Back-to-back TX then RX: second handshake lands in cycle 6
    push_tx(4'h5);
    send_cmd(2'b00, 4'h5, w);
    repeat (5) tick();
    rsp_q.push_back(4'h6);
    send_cmd(2'b01, 4'h0, w);
    check("b2b_second_handshake", w, 32'd0);
    rx_word(4'b0110);
    #1;
    check("b2b_rsp_valid", rsp_valid, 32'd1);
    check("b2b_rsp_data", rsp_data, 32'h6);
    tick(); #1;
    check("b2b_ready", cmd_ready, 32'd1);

    // Reserved op: accepted, no operation
    send_cmd(2'b10, 4'h3, w);
    #1;
    check("reserved_ready", cmd_ready, 32'd1);
    check("reserved_enable", reg_enable, 32'd0);

    // Fault counter: 60 TX commands x 5 enabled cycles = 300 -> saturate
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    #1 check("fault_cleared", fault_cnt, 32'd0);
    fault_in = 1'b1;
    for (int n = 0; n < 60; n++) begin
      push_tx(4'(n));
      send_cmd(2'b00, 4'(n), w);
      repeat (5) tick();
      if (n == 9) check("fault_cnt_50", fault_cnt, 32'd50);
    end
    check("fault_cnt_sat", fault_cnt, 32'd255);
    push_tx(4'hF);
    send_cmd(2'b00, 4'hF, w);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    fault_in  = 1'b0;
    #1 check("fault_clr_wins", fault_cnt, 32'd0);
    repeat (4) tick();

    // Reset in cycle 3 of a TX: only the cycle-2 bit is ever seen
    tx_q.push_back(1'b1);
    send_cmd(2'b00, 4'h3, w);
    tick();
    tick();
    rst = 1'b0;
    #1 check_reset("rst_mid_tx");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("post_rst_ready", cmd_ready, 32'd1);
      check("post_rst_tx_valid", tx_valid, 32'd0);
      check("post_rst_rsp_valid", rsp_valid, 32'd0);
    end

    check("tx_q_empty", tx_q.size(), 32'd0);
    check("rsp_q_empty", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
